// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: opcode constants, FSM state encoding and next-PC select codes for pc_seq_ctrl.
package pc_seq_pkg;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_RETI = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;
  typedef enum logic [1:0] {FETCH, DECODE, OPERAND, HALT} state_t;
  typedef enum logic [1:0] {SEL_INCR, SEL_TARGET, SEL_VECTOR, SEL_EPC} pc_sel_t;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC mux choosing increment, branch target, IRQ vector or saved EPC.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  pc_sel_t           sel_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] vector_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] next_pc_o
);
  always_comb begin
    next_pc_o = sel_i == SEL_TARGET ? target_i :
                sel_i == SEL_VECTOR ? vector_i :
                sel_i == SEL_EPC    ? epc_i    : pc_i + ADDR_W'(1);
  end
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch/branch sequencer driving the PC (increment, JMP, JZ, HLT, exec pulse).
// Optional interrupt entry/RETI support is enabled with `define PC_SEQ_IRQ_EN.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int                  ADDR_W     = 8,
  parameter int                  DATA_W     = 8,
  parameter logic [ADDR_W-1:0]   IRQ_VECTOR = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr,
  input  logic              mem_ready,
  input  logic              zero_flag,
  input  logic              stall,
  input  logic              irq,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] next_pc,
  output logic              pc_write_en,
  output logic [DATA_W-1:0] ir,
  output logic              exec_en,
  output logic              halted,
  output logic [ADDR_W-1:0] epc
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] epc_q, sel_pc;
  logic [3:0]        op;
  logic              run, irq_take, is_reti, is_br, take_br;
  pc_sel_t           sel;
  assign op      = ir_q[DATA_W-1 -: 4];
  assign run     = !rst && !stall;
  assign is_br   = op == OP_JMP || op == OP_JZ;
  assign take_br = op == OP_JMP || (op == OP_JZ && zero_flag);
`ifdef PC_SEQ_IRQ_EN
  logic ie_q;
  assign irq_take = run && irq && ie_q && state_q == FETCH;
  assign is_reti  = op == OP_RETI;
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q  <= 1'b1;
      epc_q <= '0;
    end else if (irq_take) begin
      ie_q  <= 1'b0;
      epc_q <= pc_in;
    end else if (run && state_q == DECODE && is_reti) begin
      ie_q  <= 1'b1;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_take   = 1'b0;
  assign is_reti    = 1'b0;
  assign epc_q      = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (!stall) begin
      case (state_q)
        FETCH: if (!irq_take && mem_ready) begin
          state_d = DECODE;
          ir_d    = instr;
        end
        DECODE:  state_d = is_br ? OPERAND : op == OP_HLT ? HALT : FETCH;
        OPERAND: state_d = mem_ready ? FETCH : OPERAND;
        default: state_d = HALT;
      endcase
    end
  end
  // Mealy outputs; every enable is squashed by reset or stall.
  always_comb begin
    mem_rd_en   = run && ((state_q == FETCH && !irq_take) || state_q == OPERAND);
    pc_write_en = run && ((state_q == FETCH && (irq_take || mem_ready)) ||
                          (state_q == OPERAND && mem_ready) ||
                          (state_q == DECODE && is_reti));
    exec_en     = run && state_q == DECODE && !is_br && op != OP_HLT && !is_reti;
    halted      = !rst && state_q == HALT;
    sel         = irq_take ? SEL_VECTOR :
                  state_q == DECODE ? SEL_EPC :
                  (state_q == OPERAND && take_br) ? SEL_TARGET : SEL_INCR;
    next_pc     = pc_write_en ? sel_pc : '0;
  end
  pc_next_sel #(.ADDR_W(ADDR_W)) u_sel (
    .sel_i    (sel),
    .pc_i     (pc_in),
    .target_i (instr[ADDR_W-1:0]),
    .vector_i (IRQ_VECTOR),
    .epc_i    (epc_q),
    .next_pc_o(sel_pc)
  );
  assign ir  = ir_q;
  assign epc = epc_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed self-checking bench for pc_seq_ctrl (IRQ steps only with PC_SEQ_IRQ_EN).
module tb_pc_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst, mem_ready, zero_flag, stall, irq;
  logic [7:0] pc_in, instr;
  logic       mem_rd_en, pc_write_en, exec_en, halted;
  logic [7:0] next_pc, ir, epc;
  int         checks = 0;
  int         failures = 0;
  pc_seq_ctrl dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr(instr), .mem_ready(mem_ready),
    .zero_flag(zero_flag), .stall(stall), .irq(irq), .mem_rd_en(mem_rd_en),
    .next_pc(next_pc), .pc_write_en(pc_write_en), .ir(ir), .exec_en(exec_en),
    .halted(halted), .epc(epc)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_en(input string tag, input logic rd, input logic we, input logic ex);
    chk({tag, ".rd"}, {7'b0, mem_rd_en}, {7'b0, rd});
    chk({tag, ".we"}, {7'b0, pc_write_en}, {7'b0, we});
    chk({tag, ".ex"}, {7'b0, exec_en}, {7'b0, ex});
  endtask
  initial begin
    rst = 1'b1; mem_ready = 1'b1; zero_flag = 1'b0; stall = 1'b0; irq = 1'b0;
    pc_in = 8'h00; instr = 8'h30;
    tick();
    #1;
    chk_en("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.next_pc", next_pc, 8'h00);
    chk("rst.halted", {7'b0, halted}, 8'h00);
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    chk_en("idle", 1'b1, 1'b0, 1'b0);
    chk("idle.ir", ir, 8'h00);
    chk("idle.halted", {7'b0, halted}, 8'h00);
    chk("idle.epc", epc, 8'h00);
    tick();
    chk_en("wait", 1'b1, 1'b0, 1'b0);
    pc_in = 8'h05; instr = 8'h30; mem_ready = 1'b1;
    #1;
    chk_en("op.fetch", 1'b1, 1'b1, 1'b0);
    chk("op.next_pc", next_pc, 8'h06);
    tick();
    mem_ready = 1'b0; pc_in = 8'h06;
    #1;
    chk("op.ir", ir, 8'h30);
    chk_en("op.exec", 1'b0, 1'b0, 1'b1);
    tick();
    chk_en("op.back", 1'b1, 1'b0, 1'b0);
    instr = 8'h10; mem_ready = 1'b1;
    #1;
    chk("jmp.fetch_pc", next_pc, 8'h07);
    tick();
    chk_en("jmp.dec", 1'b0, 1'b0, 1'b0);
    tick();
    pc_in = 8'h07; instr = 8'h40;
    #1;
    chk_en("jmp.opnd", 1'b1, 1'b1, 1'b0);
    chk("jmp.target", next_pc, 8'h40);
    tick();
    pc_in = 8'h40; instr = 8'h20;
    tick();
    tick();
    pc_in = 8'h41; instr = 8'h80; zero_flag = 1'b0;
    #1;
    chk("jz0.next_pc", next_pc, 8'h42);
    chk("jz0.we", {7'b0, pc_write_en}, 8'h01);
    tick();
    pc_in = 8'h42; instr = 8'h20;
    tick();
    tick();
    pc_in = 8'h43; instr = 8'h80; zero_flag = 1'b1;
    #1;
    chk("jz1.next_pc", next_pc, 8'h80);
    tick();
    zero_flag = 1'b0; pc_in = 8'hFF; instr = 8'h10;
    #1;
    chk("wrap.next_pc", next_pc, 8'h00);
    tick();
    tick();
    stall = 1'b1; pc_in = 8'h00; instr = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_en("stall", 1'b0, 1'b0, 1'b0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk_en("stall.held", 1'b1, 1'b1, 1'b0);
    chk("stall.next_pc", next_pc, 8'h55);
    tick();
`ifndef PC_SEQ_IRQ_EN
    pc_in = 8'h55; instr = 8'hE0; irq = 1'b1;
    #1;
    chk_en("noirq.fetch", 1'b1, 1'b1, 1'b0);
    chk("noirq.next_pc", next_pc, 8'h56);
    tick();
    irq = 1'b0;
    #1;
    chk_en("noirq.E_exec", 1'b0, 1'b0, 1'b1);
    chk("noirq.epc", epc, 8'h00);
    tick();
`else
    pc_in = 8'h55; instr = 8'h30;
    tick();
    tick();
`endif
    pc_in = 8'h56; instr = 8'hF0;
    tick();
    chk_en("hlt.dec", 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("hlt.halted", {7'b0, halted}, 8'h01);
      chk_en("hlt", 1'b0, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    chk("post.halted", {7'b0, halted}, 8'h00);
    chk("post.ir", ir, 8'h00);
    chk_en("post", 1'b1, 1'b0, 1'b0);
`ifdef PC_SEQ_IRQ_EN
    pc_in = 8'h22; irq = 1'b1; mem_ready = 1'b1; instr = 8'h30;
    #1;
    chk_en("irq.take", 1'b0, 1'b1, 1'b0);
    chk("irq.next_pc", next_pc, 8'hF0);
    tick();
    chk("irq.epc", epc, 8'h22);
    pc_in = 8'hF0; instr = 8'hE0;
    #1;
    chk_en("irq.masked", 1'b1, 1'b1, 1'b0);
    chk("irq.masked_pc", next_pc, 8'hF1);
    tick();
    irq = 1'b0; pc_in = 8'hF1;
    #1;
    chk_en("reti", 1'b0, 1'b1, 1'b0);
    chk("reti.next_pc", next_pc, 8'h22);
    tick();
    pc_in = 8'h22; irq = 1'b1;
    #1;
    chk("irq.again", next_pc, 8'hF0);
    tick();
    irq = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
